// File: rtl/turbo_enc_pkg.sv
// Shared types and sizing for the turbo encoder block controller.
package turbo_enc_pkg;

  localparam int unsigned K_SMALL_BYTES = 132;
  localparam int unsigned K_LARGE_BYTES = 768;
  localparam int unsigned CNT_W         = 10;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    CLEAR = 5'b00010,
    DATA  = 5'b00100,
    TAIL  = 5'b01000,
    DONE  = 5'b10000
  } state_t;

endpackage

// File: rtl/enc_byte_cnt.sv
// Loadable byte counter with a terminal-count flag at limit-1.
module enc_byte_cnt
  import turbo_enc_pkg::*;
(
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == limit - CNT_W'(1));

endmodule

// File: rtl/turbo_enc_ctrl.sv
// Turbo encoder block controller: clear, stream k_size bytes, tail, done.
// Optional abort input enabled by TURBO_ENC_CTRL_ABORT_EN.
module turbo_enc_ctrl
  import turbo_enc_pkg::*;
#(
  parameter int unsigned K_SMALL_BYTES = turbo_enc_pkg::K_SMALL_BYTES,
  parameter int unsigned K_LARGE_BYTES = turbo_enc_pkg::K_LARGE_BYTES
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             K,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
`ifdef TURBO_ENC_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             in_ready,
  input  logic             out_ready,
  output logic             enc_clr,
  output logic             enc_en,
  output logic [7:0]       enc_ck,
  output logic             tail_strobe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam logic [CNT_W-1:0] K_S = CNT_W'(K_SMALL_BYTES);
  localparam logic [CNT_W-1:0] K_L = CNT_W'(K_LARGE_BYTES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] k_size;
  logic             start_acc;
  logic             cnt_clr;
  logic             cnt_tc;

  assign start_acc = start && (state_q == IDLE);
  assign in_ready  = (state_q == DATA) && out_ready;
  assign enc_en    = in_valid && in_ready;
  assign enc_ck    = in_data;

`ifdef TURBO_ENC_CTRL_ABORT_EN
  assign cnt_clr = start_acc || (abort && busy);
`else
  assign cnt_clr = start_acc;
`endif

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      k_size  <= K_S;
    end else begin
      state_q <= state_d;
      if (start_acc) k_size <= K ? K_L : K_S;
    end
  end

  always_comb begin
    state_d     = state_q;
    enc_clr     = 1'b0;
    tail_strobe = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        enc_clr = 1'b1;
        busy    = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        busy = 1'b1;
        if (enc_en && cnt_tc) state_d = TAIL;
      end
      TAIL: begin
        tail_strobe = 1'b1;
        busy        = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef TURBO_ENC_CTRL_ABORT_EN
    // An abort landing in TAIL also suppresses that cycle's tail marker.
    if (abort && busy) begin
      state_d     = IDLE;
      tail_strobe = 1'b0;
    end
`endif
  end

  enc_byte_cnt u_cnt (
    .clk    (clk),
    .aclr_n (aclr_n),
    .clr    (cnt_clr),
    .inc    (enc_en),
    .limit  (k_size),
    .cnt    (byte_cnt),
    .tc     (cnt_tc)
  );

endmodule
